// File: rtl/iir_sched_pkg.sv
// rtl/iir_sched_pkg.sv - widths, FSM states, coefficient map and MAC helper for iir_chan_scheduler
package iir_sched_pkg;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int CW  = 18;
  localparam int SW  = 32;
  localparam int PW  = 48;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {IDLE, CAPT, CALC, STORE, DONE} state_e;

  localparam logic [2:0] ADDR_N1 = 3'd0;
  localparam logic [2:0] ADDR_N2 = 3'd1;
  localparam logic [2:0] ADDR_N3 = 3'd2;
  localparam logic [2:0] ADDR_D1 = 3'd3;
  localparam logic [2:0] ADDR_D2 = 3'd4;

  localparam logic [CW-1:0] N1_DEFAULT = 18'h07809;
  localparam logic [CW-1:0] N2_DEFAULT = 18'h31778;
  localparam logic [CW-1:0] N3_DEFAULT = 18'h07C1E;
  localparam logic [CW-1:0] D1_DEFAULT = 18'h0F19C;
  localparam logic [CW-1:0] D2_DEFAULT = 18'h38E4C;

  typedef struct packed {
    logic [SW-1:0] x1;
    logic [SW-1:0] x2;
    logic [SW-1:0] y1;
    logic [SW-1:0] y2;
  } hist_t;

  // Signed Q16.16 x Q3.15 product kept to 48 bits; upper bits wrap away.
  function automatic logic [PW-1:0] mul_wrap(input logic [SW-1:0] a, input logic [CW-1:0] c);
    logic signed [PW-1:0] ae;
    logic signed [PW-1:0] ce;
    ae = {{(PW-SW){a[SW-1]}}, a};
    ce = {{(PW-CW){c[CW-1]}}, c};
    return ae * ce;
  endfunction

endpackage

// File: rtl/iir_sos_core.sv
// rtl/iir_sos_core.sv - combinational five-tap second-order section with a 48-bit wrapping sum
module iir_sos_core
  import iir_sched_pkg::*;
(
  input  logic [CW-1:0] n1_i,
  input  logic [CW-1:0] n2_i,
  input  logic [CW-1:0] n3_i,
  input  logic [CW-1:0] d1_i,
  input  logic [CW-1:0] d2_i,
  input  logic [SW-1:0] xs_i,
  input  logic [SW-1:0] x1_i,
  input  logic [SW-1:0] x2_i,
  input  logic [SW-1:0] y1_i,
  input  logic [SW-1:0] y2_i,
  output logic [PW-1:0] sum_o
);

  assign sum_o = mul_wrap(xs_i, n1_i) + mul_wrap(x1_i, n2_i) + mul_wrap(x2_i, n3_i)
               + mul_wrap(y1_i, d1_i) + mul_wrap(y2_i, d2_i);

endmodule

// File: rtl/iir_chan_scheduler.sv
// rtl/iir_chan_scheduler.sv - serialises NCH channels of a frame through one shared IIR core
module iir_chan_scheduler
  import iir_sched_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [NCH*DW-1:0] x_data,
  input  logic [NCH-1:0]    chan_en,
  input  logic [NCH-1:0]    chan_clr,
  output logic              y_valid,
  output logic [NCH*DW-1:0] y_data,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [CW-1:0]     cfg_data,
  output logic              cfg_ready,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic [NCH*DW-1:0] x_q, y_q;
  logic [NCH-1:0]    en_q, pend_q;
  logic [SW-1:0]     acc_q;
  logic              y_valid_q;
  logic [CW-1:0]     n1_q, n2_q, n3_q, d1_q, d2_q;
  hist_t             hist_q [NCH];

  logic              accept, cfg_acc;
  logic [DW-1:0]     x_cur;
  logic [SW-1:0]     xs_cur;
  hist_t             h_cur;
  logic [PW-1:0]     sum;
  logic              unused_sum_bits;

  assign x_ready   = (state_q == IDLE) && !cfg_we;
  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign y_valid   = y_valid_q;
  assign y_data    = y_q;
  assign accept    = x_valid && x_ready;
  assign cfg_acc   = cfg_we && cfg_ready;

  assign x_cur  = x_q[ch_q*DW +: DW];
  assign xs_cur = {x_cur, {(SW-DW){1'b0}}};
  assign h_cur  = hist_q[ch_q];

  iir_sos_core u_core (
    .n1_i  (n1_q),
    .n2_i  (n2_q),
    .n3_i  (n3_q),
    .d1_i  (d1_q),
    .d2_i  (d2_q),
    .xs_i  (xs_cur),
    .x1_i  (h_cur.x1),
    .x2_i  (h_cur.x2),
    .y1_i  (h_cur.y1),
    .y2_i  (h_cur.y2),
    .sum_o (sum)
  );

  // Only sum[46:15] is architecturally visible (new y1, and its top half is the sample).
  assign unused_sum_bits = ^{sum[PW-1], sum[PW-2-SW:0]};

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      IDLE:  if (accept) state_d = CAPT;
      CAPT: begin
        ch_d    = '0;
        state_d = CALC;
      end
      CALC:  state_d = STORE;
      STORE: begin
        if (ch_q == CHW'(NCH-1)) begin
          state_d = DONE;
        end else begin
          ch_d    = ch_q + CHW'(1);
          state_d = CALC;
        end
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_q       <= '0;
      y_q       <= '0;
      en_q      <= '0;
      pend_q    <= '0;
      acc_q     <= '0;
      y_valid_q <= 1'b0;
      n1_q      <= N1_DEFAULT;
      n2_q      <= N2_DEFAULT;
      n3_q      <= N3_DEFAULT;
      d1_q      <= D1_DEFAULT;
      d2_q      <= D2_DEFAULT;
      for (int i = 0; i < NCH; i++) hist_q[i] <= '0;
    end else begin
      y_valid_q <= (state_q == DONE);

      if (cfg_acc) begin
        case (cfg_addr)
          ADDR_N1: n1_q <= cfg_data;
          ADDR_N2: n2_q <= cfg_data;
          ADDR_N3: n3_q <= cfg_data;
          ADDR_D1: d1_q <= cfg_data;
          ADDR_D2: d2_q <= cfg_data;
          default: ;
        endcase
      end

      if (accept) begin
        x_q  <= x_data;
        en_q <= chan_en;
      end

      if (state_q == CALC) acc_q <= sum[PW-2 -: SW];

      // Bypassed slots keep their original timing so latency never depends on chan_en.
      if (state_q == STORE) begin
        if (en_q[ch_q]) begin
          hist_q[ch_q].x1 <= xs_cur;
          hist_q[ch_q].x2 <= h_cur.x1;
          hist_q[ch_q].y1 <= acc_q;
          hist_q[ch_q].y2 <= h_cur.y1;
          y_q[ch_q*DW +: DW] <= acc_q[SW-1 -: DW];
        end else begin
          y_q[ch_q*DW +: DW] <= x_cur;
        end
      end

      if (state_q == DONE) begin
        pend_q <= '0;
      end else if (state_q != IDLE) begin
        pend_q <= pend_q | chan_clr;
      end

      for (int i = 0; i < NCH; i++) begin
        if ((state_q == IDLE && chan_clr[i]) ||
            (state_q == DONE && (pend_q[i] || chan_clr[i]))) begin
          hist_q[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_iir_chan_scheduler.sv
// tb/tb_iir_chan_scheduler.sv - table-driven scoreboard bench for iir_chan_scheduler
module tb_iir_chan_scheduler;
  import iir_sched_pkg::*;

  localparam int LAT = 2*NCH + 2;

  logic              clk;
  logic              reset_n;
  logic              x_valid;
  logic              x_ready;
  logic [NCH*DW-1:0] x_data;
  logic [NCH-1:0]    chan_en;
  logic [NCH-1:0]    chan_clr;
  logic              y_valid;
  logic [NCH*DW-1:0] y_data;
  logic              cfg_we;
  logic [2:0]        cfg_addr;
  logic [CW-1:0]     cfg_data;
  logic              cfg_ready;
  logic              busy;

  iir_chan_scheduler dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .x_data    (x_data),
    .chan_en   (chan_en),
    .chan_clr  (chan_clr),
    .y_valid   (y_valid),
    .y_data    (y_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NCH*DW-1:0] x;
    logic [NCH-1:0]    en;
    logic [NCH-1:0]    clr_acc;
    logic [NCH-1:0]    clr_mid;
    logic [NCH*DW-1:0] y;
  } vec_t;

  vec_t              tbl [8];
  logic [NCH*DW-1:0] exp_q [$];
  int                n_cmp = 0;
  int                n_bad = 0;
  int                yv_count = 0;
  int                yv_snap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && y_valid) begin
      yv_count++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_y_valid: got y_data %h, want no output", y_data);
      end else begin
        check($sformatf("y_data_out%0d", yv_count), y_data, exp_q.pop_front());
      end
    end
  end

  // Called just after a posedge with the DUT idle or about to be.
  task automatic run_frame(input logic [NCH*DW-1:0] x, input logic [NCH-1:0] en,
                           input logic [NCH-1:0] clr_acc, input logic [NCH-1:0] clr_mid,
                           input logic [NCH*DW-1:0] exp, input string tag);
    int n;
    bit ok;
    x_data = x; chan_en = en; chan_clr = clr_acc; x_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (x_ready) begin ok = 1; break; end
    end
    check({"accept_", tag}, 64'(ok), 64'd1);
    if (!ok) begin
      x_valid = 1'b0; chan_clr = '0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    x_valid = 1'b0; chan_clr = '0; x_data = ~x; chan_en = ~en;
    n = 0; ok = 0;
    while (n < 40 && !ok) begin
      @(posedge clk);
      n++;
      #1;
      chan_clr = (n == 3) ? clr_mid : '0;
      if (n == 2) begin
        check({"busy_mid_", tag}, 64'(busy), 64'd1);
        check({"cfg_ready_mid_", tag}, 64'(cfg_ready), 64'd0);
      end
      ok = y_valid;
    end
    check({"latency_", tag}, 64'(n), 64'(LAT));
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [CW-1:0] d);
    bit ok;
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (cfg_ready) begin ok = 1; break; end
    end
    check($sformatf("cfg_accept_a%0d", a), 64'(ok), 64'd1);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{64'h0000_0010_0000_0100, 4'hF, 4'hF, 4'h0, 64'h0000_0010_0000_0100};
    tbl[1] = '{64'h0000_0010_0000_0100, 4'hF, 4'h0, 4'h0, 64'h0000_0020_0000_0200};
    tbl[2] = '{64'h0000_0010_0000_0100, 4'hF, 4'h0, 4'h0, 64'h0000_0030_0000_0300};
    tbl[3] = '{64'h0000_0010_0000_0100, 4'hF, 4'h0, 4'h1, 64'h0000_0040_0000_0400};
    tbl[4] = '{64'h0000_0010_0000_0100, 4'hF, 4'h0, 4'h0, 64'h0000_0050_0000_0100};
    tbl[5] = '{64'h0055_0055_0055_0055, 4'hA, 4'h0, 4'h0, 64'h0055_0055_0055_0055};
    tbl[6] = '{64'h0055_0055_0055_0055, 4'hF, 4'h0, 4'h0, 64'h00AA_00A5_00AA_0155};
    tbl[7] = '{64'h7FFF_0000_0000_0000, 4'hF, 4'h0, 4'h0, 64'h80A9_00A5_00AA_0155};

    reset_n = 1'b0; x_valid = 1'b0; x_data = '0; chan_en = '0; chan_clr = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_y_valid", 64'(y_valid), 64'd0);
    check("reset_y_data", y_data, 64'd0);
    check("reset_x_ready", 64'(x_ready), 64'd1);
    check("reset_cfg_ready", 64'(cfg_ready), 64'd1);
    @(posedge clk); #1;

    run_frame('0, 4'hF, 4'h0, 4'h0, '0, "zero");

    cfg_write(ADDR_N1, 18'h08000);
    cfg_write(ADDR_N2, 18'h00000);
    cfg_write(ADDR_N3, 18'h00000);
    cfg_write(ADDR_D1, 18'h00000);
    cfg_write(ADDR_D2, 18'h00000);
    run_frame(64'h8000_7FFF_FEDC_1234, 4'hF, 4'h0, 4'h0, 64'h8000_7FFF_FEDC_1234, "identity");

    cfg_write(ADDR_D1, 18'h08000);
    for (int i = 0; i < 8; i++)
      run_frame(tbl[i].x, tbl[i].en, tbl[i].clr_acc, tbl[i].clr_mid, tbl[i].y, $sformatf("tbl%0d", i));

    // Config write and frame offered together: the write must win the cycle.
    cfg_we = 1'b1; cfg_addr = ADDR_N1; cfg_data = 18'h10000;
    x_valid = 1'b1; x_data = 64'h0010_0010_0010_0010; chan_en = 4'hF;
    @(negedge clk);
    check("x_ready_cfg_conflict", 64'(x_ready), 64'd0);
    check("cfg_ready_cfg_conflict", 64'(cfg_ready), 64'd1);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    run_frame(64'h0010_0010_0010_0010, 4'hF, 4'hF, 4'h0, 64'h0020_0020_0020_0020, "cfg_first");

    // Reset while the first channel is in CALC.
    x_valid = 1'b1; x_data = 64'h1111_2222_3333_4444; chan_en = 4'hF;
    @(negedge clk);
    check("abort_accept", 64'(x_ready), 64'd1);
    @(posedge clk); #1;
    x_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_busy_before", 64'(busy), 64'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_y_valid", 64'(y_valid), 64'd0);
    check("abort_y_data", y_data, 64'd0);
    yv_snap = yv_count;
    repeat (15) @(posedge clk);
    check("abort_no_y_valid", 64'(yv_count), 64'(yv_snap));
    #1;

    cfg_write(3'd5, 18'h00000);
    cfg_write(3'd7, 18'h3FFFF);
    run_frame(64'h0000_0000_0000_4000, 4'hF, 4'h0, 4'h0, 64'h0000_0000_0000_3C04, "default1");
    run_frame(64'h0000_0000_0000_0000, 4'hF, 4'h0, 4'h0, 64'h0000_0000_0000_FD05, "default2");

    for (int k = 0; k < 50; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
